mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port backing memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage core. Exactly one transaction is outstanding at a time. Data requests win by default; a streak counter keeps fetch from being starved. A fetch flush input discards an in-flight instruction response when the pipeline redirects the PC.

## Interface

- `ADDR_W`, default 32: address width of all three ports.
- `DATA_W`, default 32: data width of all three ports.
- `MAX_D_STREAK`, default 4: maximum number of consecutive data grants while fetch is waiting. Legal range 1–15.

Ports (name, direction, width, meaning):

- `i_clk` in 1: the block's one clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_if_req` in 1: fetch read request.
- `i_if_addr` in ADDR_W: fetch address.
- `i_if_flush` in 1: discard the pending fetch response.
- `o_if_gnt` out 1: fetch request accepted this cycle.
- `o_if_rvalid` out 1: fetch read data valid.
- `o_if_rdata` out DATA_W: fetch read data.
- `i_d_req` in 1: data request.
- `i_d_we` in 1: data write enable; 1 = store.
- `i_d_be` in DATA_W/8: store byte enables.
- `i_d_addr` in ADDR_W: data address.
- `i_d_wdata` in DATA_W: store data.
- `o_d_gnt` out 1: data request accepted this cycle.
- `o_d_rvalid` out 1: load data valid, or store acknowledge.
- `o_d_rdata` out DATA_W: load data.
- `o_m_req` out 1: memory request.
- `o_m_we` out 1: memory write enable.
- `o_m_be` out DATA_W/8: memory byte enables.
- `o_m_addr` out ADDR_W: memory address.
- `o_m_wdata` out DATA_W: memory write data.
- `i_m_gnt` in 1: memory accepts the request.
- `i_m_rvalid` in 1: memory response; asserted for reads and writes.
- `i_m_rdata` in DATA_W: memory read data.

## Operation

States:
- `IDLE`: may issue a request.
- `WAIT_IF`: a fetch is outstanding.
- `WAIT_D`: a data access is outstanding.

Request handshake:
- A requester holds req and all fields stable until it sees its gnt in the same cycle.
- Selection, combinational, in IDLE only:
  - Data is selected if `i_d_req` is high, unless `i_if_req` is high and `streak == MAX_D_STREAK`. In that case fetch is selected.
  - Otherwise fetch is selected if `i_if_req` is high.
- `o_m_req` = IDLE and a requester is selected. The `o_m_*` fields are muxed from the selected requester.
- With no selection, all `o_m_*` outputs are 0. Fetch always drives `we=0` and `be=0`.
- `o_if_gnt` / `o_d_gnt` = `o_m_req` & `i_m_gnt` & (that requester is selected).
- On a grant, the state moves to WAIT_IF or WAIT_D. Without `i_m_gnt` the state stays IDLE, and selection is re-evaluated the next cycle.

Streak counter (4 bits):
- Data grant while `i_if_req` is high: increment.
- Data grant while `i_if_req` is low: clear.
- Fetch grant: clear.
- It never exceeds `MAX_D_STREAK`.

Responses:
- In WAIT_IF, `i_m_rvalid` is forwarded as `o_if_rvalid`, with `o_if_rdata` = `i_m_rdata`. This is suppressed if the flush flag is set or `i_if_flush` is high that cycle. The state then returns to IDLE.
- In WAIT_D, `i_m_rvalid` is forwarded as `o_d_rvalid`, with `o_d_rdata` = `i_m_rdata`, and the state returns to IDLE.
- `o_*_rdata` is 0 whenever the matching rvalid is low.
- `i_m_rvalid` in IDLE is ignored: nothing is forwarded and the state does not change.

Flush flag:
- Set by `i_if_flush` while in WAIT_IF, or in the cycle of a fetch grant.
- Cleared when leaving WAIT_IF.
- `i_if_flush` in IDLE with no fetch grant has no effect.

## Timing

- Reset, asynchronous on `i_rst_n` low: state IDLE, streak 0, flush flag 0.
  - All registered state clears immediately. Outputs reduce to their combinational functions of the inputs.
  - With all req inputs low, every output is 0.
- Reset mid-transaction: the outstanding access is abandoned. A later `i_m_rvalid` arrives in IDLE and is ignored.
- Grant latency: 0 cycles (gnt is combinational from req) when IDLE and `i_m_gnt` is high.
- Response path: combinational, 0 cycles from `i_m_rvalid`.
- No new request is issued in the cycle a response returns; the state is still WAIT_* during that cycle. Minimum spacing between grants is 2 cycles for a 1-cycle memory.
- Simultaneous fetch and data requests: data wins unless the streak has reached its limit.
- Flush and rvalid in the same cycle: the response is dropped.

## Test plan

- **Reset.** Hold `i_rst_n`=0 with reqs low; then release with reqs low -> all outputs 0, state IDLE.
- **Fetch read.** Fetch req at addr 0x100; memory gnt same cycle; rvalid 1 cycle later with 0xDEADBEEF -> `o_if_gnt`=1 in cycle 0; `o_if_rvalid`=1 with rdata 0xDEADBEEF in cycle 1; no `o_m_req` in cycle 1.
- **Store.** Data store: addr 0x200, be=4'b0011, wdata 0x1234 -> `o_m_we`=1, `o_m_be`=0011, `o_m_wdata`=0x1234; ack appears on `o_d_rvalid` with `o_d_rdata`=0.
- **Starvation guard.** Fetch and data requests held continuously, `MAX_D_STREAK`=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- **Flush.** Fetch granted; `i_if_flush` pulsed 1 cycle; rvalid 3 cycles later -> `o_if_rvalid` stays 0; state returns to IDLE; the next fetch is granted normally.
- **Mid-transaction reset.** Reset asserted in WAIT_D, then released; memory returns stale rvalid -> `o_d_rvalid` stays 0; streak 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Ports: i_if_* fetch, i_d_* data, o_m_*/i_m_* backing memory; one outstanding access.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [DATA_W/8-1:0] i_d_be,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    output logic                o_d_gnt,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_m_req,
    output logic                o_m_we,
    output logic [DATA_W/8-1:0] o_m_be,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    input  logic                i_m_gnt,
    input  logic                i_m_rvalid,
    input  logic [DATA_W-1:0]   i_m_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_D
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       flush_q, flush_d;
    logic       sel_if, sel_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            flush_q  <= flush_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        flush_d     = flush_q;
        sel_if      = 1'b0;
        sel_d       = 1'b0;
        o_m_req     = 1'b0;
        o_m_we      = 1'b0;
        o_m_be      = '0;
        o_m_addr    = '0;
        o_m_wdata   = '0;
        o_if_gnt    = 1'b0;
        o_d_gnt     = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_d_rvalid  = 1'b0;
        o_d_rdata   = '0;

        // Data wins unless fetch has waited through a full streak.
        if (state_q == IDLE) begin
            if (i_d_req && !(i_if_req && streak_q == STREAK_MAX)) begin
                sel_d = 1'b1;
            end else if (i_if_req) begin
                sel_if = 1'b1;
            end
        end

        if (sel_d) begin
            o_m_req   = 1'b1;
            o_m_we    = i_d_we;
            o_m_be    = i_d_be;
            o_m_addr  = i_d_addr;
            o_m_wdata = i_d_wdata;
        end else if (sel_if) begin
            o_m_req  = 1'b1;
            o_m_addr = i_if_addr;
        end

        o_if_gnt = sel_if & i_m_gnt;
        o_d_gnt  = sel_d & i_m_gnt;

        unique case (state_q)
            IDLE: begin
                if (o_if_gnt) begin
                    state_d  = WAIT_IF;
                    streak_d = 4'd0;
                    flush_d  = i_if_flush;
                end else if (o_d_gnt) begin
                    state_d = WAIT_D;
                    if (!i_if_req) begin
                        streak_d = 4'd0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end
            end
            WAIT_IF: begin
                if (i_m_rvalid) begin
                    // A flush, earlier or in this very cycle, drops the data.
                    o_if_rvalid = !(flush_q || i_if_flush);
                    o_if_rdata  = o_if_rvalid ? i_m_rdata : '0;
                    state_d     = IDLE;
                    flush_d     = 1'b0;
                end else if (i_if_flush) begin
                    flush_d = 1'b1;
                end
            end
            WAIT_D: begin
                if (i_m_rvalid) begin
                    o_d_rvalid = 1'b1;
                    o_d_rdata  = i_m_rdata;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Per-cycle model compare plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    int    checks;
    int    failures;
    int    m_own;
    int    m_streak;
    bit    m_fl;
    bit    e_ig, e_dg;
    bit    mem_pend;
    string tr;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be),
        .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_m_req(m_req), .o_m_we(m_we), .o_m_be(m_be),
        .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .i_m_gnt(m_gnt), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endfunction

    // Model: who owns the memory (0 none, 1 fetch, 2 data), streak, drop flag.
    task automatic settle();
        int pick;
        bit ev;
        #1;
        pick = 0;
        if (m_own == 0) begin
            if (d_req && !(if_req && m_streak == MAXS)) pick = 2;
            else if (if_req) pick = 1;
        end
        e_ig = (pick == 1) && m_gnt;
        e_dg = (pick == 2) && m_gnt;
        chk("m_req", 64'(m_req), 64'(pick != 0));
        chk("m_we", 64'(m_we), 64'(pick == 2 && d_we));
        chk("m_be", 64'(m_be), 64'(pick == 2 ? d_be : 4'd0));
        chk("m_addr", 64'(m_addr),
            64'(pick == 2 ? d_addr : (pick == 1 ? if_addr : 32'd0)));
        chk("m_wdata", 64'(m_wdata), 64'(pick == 2 ? d_wdata : 32'd0));
        chk("if_gnt", 64'(if_gnt), 64'(e_ig));
        chk("d_gnt", 64'(d_gnt), 64'(e_dg));
        ev = (m_own == 1) && m_rvalid && !m_fl && !if_flush;
        chk("if_rvalid", 64'(if_rvalid), 64'(ev));
        chk("if_rdata", 64'(if_rdata), 64'(ev ? m_rdata : 32'd0));
        ev = (m_own == 2) && m_rvalid;
        chk("d_rvalid", 64'(d_rvalid), 64'(ev));
        chk("d_rdata", 64'(d_rdata), 64'(ev ? m_rdata : 32'd0));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) begin
            if (m_own == 1 && m_rvalid) begin
                m_own = 0;
                m_fl  = 0;
            end else if (m_own == 1 && if_flush) begin
                m_fl = 1;
            end else if (m_own == 2 && m_rvalid) begin
                m_own = 0;
            end else if (e_ig) begin
                m_own    = 1;
                m_streak = 0;
                m_fl     = if_flush;
            end else if (e_dg) begin
                m_own    = 2;
                m_streak = if_req ? m_streak + 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic quiet();
        if_req   = 0; if_flush = 0; d_req = 0; d_we = 0;
        m_gnt    = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n    = 0;
        m_own    = 0;
        m_streak = 0;
        m_fl     = 0;
    endtask

    // Both requesters held, 1-cycle memory; record grant order.
    task automatic run_both(input int n);
        int g;
        g        = 0;
        tr       = "";
        mem_pend = 0;
        for (int c = 0; c < 60 && g < n; c++) begin
            if_req   = 1; if_addr = 32'h400 + 32'(c * 4);
            d_req    = 1; d_we = 0; d_addr = 32'h800 + 32'(c * 4);
            m_gnt    = 1; m_rvalid = mem_pend;
            m_rdata  = 32'h5000 + 32'(c);
            settle();
            mem_pend = 0;
            if (d_gnt) begin tr = {tr, "D"}; g++; mem_pend = 1; end
            if (if_gnt) begin tr = {tr, "I"}; g++; mem_pend = 1; end
            adv();
        end
        if (g < n) chk("run_both_timeout", 64'(g), 64'(n));
        if_req = 0; d_req = 0; m_rvalid = 0;
    endtask

    task automatic drain();
        quiet();
        m_rvalid = 1;
        m_rdata  = 32'h0BAD0BAD;
        tick();
        m_rvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        if_addr = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        quiet();
        do_reset();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1;
        settle();
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        adv();

        if_req = 1; if_addr = 32'h100; m_gnt = 1;
        settle();
        chk("fetch_gnt", 64'(if_gnt), 64'd1);
        chk("fetch_addr", 64'(m_addr), 64'h100);
        adv();
        if_req = 0; m_gnt = 1; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        d_req = 1; d_addr = 32'h300;
        settle();
        chk("fetch_rvalid", 64'(if_rvalid), 64'd1);
        chk("fetch_rdata", 64'(if_rdata), 64'hDEADBEEF);
        chk("fetch_no_mreq", 64'(m_req), 64'd0);
        adv();
        quiet();
        tick();

        d_req = 1; d_we = 1; d_be = 4'b0011;
        d_addr = 32'h200; d_wdata = 32'h1234; m_gnt = 1;
        settle();
        chk("st_we", 64'(m_we), 64'd1);
        chk("st_be", 64'(m_be), 64'h3);
        chk("st_wdata", 64'(m_wdata), 64'h1234);
        chk("st_gnt", 64'(d_gnt), 64'd1);
        adv();
        quiet();
        m_rvalid = 1; m_rdata = 32'h0;
        settle();
        chk("st_ack", 64'(d_rvalid), 64'd1);
        chk("st_ack_rdata", 64'(d_rdata), 64'd0);
        adv();
        quiet();

        d_req = 1; d_addr = 32'h240; d_be = 4'hF;
        tick();
        m_gnt = 1;
        tick();
        quiet();
        tick();
        m_rvalid = 1; m_rdata = 32'hA5A5_0001;
        settle();
        chk("ld_rdata", 64'(d_rdata), 64'hA5A50001);
        adv();
        quiet();

        run_both(10);
        chk("starve_order", 64'(tr == "DDDDIDDDDI"), 64'd1);
        drain();

        if_req = 1; if_addr = 32'h180; m_gnt = 1;
        tick();
        quiet();
        if_flush = 1;
        tick();
        if_flush = 0;
        tick();
        tick();
        m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        settle();
        chk("flush_drop", 64'(if_rvalid), 64'd0);
        adv();
        quiet();
        if_flush = 1;
        tick();
        if_flush = 0; if_req = 1; if_addr = 32'h104; m_gnt = 1;
        settle();
        chk("post_flush_gnt", 64'(if_gnt), 64'd1);
        adv();
        quiet();
        m_rvalid = 1; m_rdata = 32'h11111111;
        settle();
        chk("post_flush_data", 64'(if_rdata), 64'h11111111);
        adv();
        quiet();

        if_req = 1; if_flush = 1; m_gnt = 1;
        tick();
        quiet();
        m_rvalid = 1; m_rdata = 32'h22222222;
        tick();
        quiet();
        if_req = 1; m_gnt = 1;
        tick();
        quiet();
        if_flush = 1; m_rvalid = 1; m_rdata = 32'h33333333;
        settle();
        chk("flush_same_cycle", 64'(if_rvalid), 64'd0);
        adv();
        quiet();

        run_both(3);
        chk("pre_reset_order", 64'(tr == "DDD"), 64'd1);
        quiet();
        do_reset();
        tick();
        rst_n = 1;
        m_rvalid = 1; m_rdata = 32'h44444444;
        settle();
        chk("stale_rvalid", 64'(d_rvalid), 64'd0);
        adv();
        quiet();
        run_both(5);
        chk("streak_cleared", 64'(tr == "DDDDI"), 64'd1);
        drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
